imx_frame_decoder: RTL

IMX_FRAME_DECODER -- requirements
Module: imx_frame_decoder

---
 rtl/imx_frame_decoder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/imx_frame_decoder.sv
// Camera line/frame decoder: tracks VS/HS framing, locks onto a 4-byte line sync on lane 0,
// and qualifies active-line words while keeping line, pixel and frame statistics.
module imx_frame_decoder #(
    parameter int unsigned LANE_WIDTH   = 8,
    parameter int unsigned SYNC_TIMEOUT = 32,
    parameter logic [7:0]  SYNC_0       = 8'h7F,
    parameter logic [7:0]  SYNC_1       = 8'h80,
    parameter logic [7:0]  SYNC_2       = 8'h00,
    parameter logic [7:0]  SYNC_3       = 8'h40
) (
    input  logic                    i_cam_clk,
    input  logic                    i_cam_rst,
    input  logic                    i_enable,
    input  logic                    i_vs,
    input  logic                    i_hs,
    input  logic [8*LANE_WIDTH-1:0] i_raw_data,
    output logic [8*LANE_WIDTH-1:0] o_data,
    output logic                    o_data_valid,
    output logic                    o_frame_start,
    output logic                    o_frame_end,
    output logic                    o_line_start,
    output logic                    o_sync_error,
    output logic [15:0]             o_line_count,
    output logic [15:0]             o_pixel_count,
    output logic [31:0]             o_frame_count,
    output logic                    o_busy
);

    localparam int unsigned TW = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StFrame, StSync, StActive, StSkip} state_e;

    state_e                  state_q, state_d;
    logic                    vs_q, hs_q;
    logic [1:0]              sync_idx_q, sync_idx_d;
    logic [TW-1:0]           timeout_q, timeout_d, timeout_inc;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [15:0]             line_count_q, line_count_d;
    logic [15:0]             pixel_count_q, pixel_count_d;
    logic [31:0]             frame_count_q, frame_count_d;
    logic [8*LANE_WIDTH-1:0] data_q, data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    frame_start_q, frame_start_d;
    logic                    frame_end_q, frame_end_d;
    logic                    line_start_q, line_start_d;
    logic                    sync_error_q, sync_error_d;

    logic       vs_rise, vs_fall, hs_rise, hs_fall;
    logic       line_done, frame_done;
    logic [7:0] lane0, sync_exp;

    assign vs_rise = i_vs & ~vs_q;
    assign vs_fall = ~i_vs & vs_q;
    assign hs_rise = i_hs & ~hs_q;
    assign hs_fall = ~i_hs & hs_q;
    assign lane0   = i_raw_data[7:0];

    always_comb begin
        sync_exp = SYNC_0;
        unique case (sync_idx_q)
            2'd0: sync_exp = SYNC_0;
            2'd1: sync_exp = SYNC_1;
            2'd2: sync_exp = SYNC_2;
            2'd3: sync_exp = SYNC_3;
            default: sync_exp = SYNC_0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        sync_idx_d    = sync_idx_q;
        timeout_d     = timeout_q;
        word_cnt_d    = word_cnt_q;
        line_count_d  = line_count_q;
        pixel_count_d = pixel_count_q;
        frame_count_d = frame_count_q;
        data_d        = i_raw_data;
        data_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_start_d  = 1'b0;
        sync_error_d  = 1'b0;
        timeout_inc   = timeout_q + TW'(1);
        line_done     = 1'b0;
        frame_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (vs_rise && i_enable) begin
                    state_d       = StFrame;
                    frame_start_d = 1'b1;
                    line_count_d  = '0;
                end
            end
            StFrame: begin
                // Frame end takes priority over a coincident line start.
                if (vs_fall) begin
                    frame_done = 1'b1;
                end else if (hs_rise) begin
                    state_d      = StSync;
                    sync_idx_d   = '0;
                    timeout_d    = '0;
                    line_start_d = 1'b1;
                end
            end
            StSync: begin
                if (vs_fall) begin
                    frame_done = 1'b1;
                end else if (hs_fall) begin
                    state_d      = StFrame;
                    sync_error_d = 1'b1;
                end else if (sync_idx_q == 2'd0) begin
                    if (lane0 == SYNC_0) begin
                        sync_idx_d = 2'd1;
                    end else begin
                        timeout_d = timeout_inc;
                        if (timeout_inc == TW'(SYNC_TIMEOUT)) begin
                            state_d      = StSkip;
                            sync_error_d = 1'b1;
                        end
                    end
                end else if (lane0 == sync_exp) begin
                    if (sync_idx_q == 2'd3) begin
                        state_d    = StActive;
                        word_cnt_d = '0;
                    end else begin
                        sync_idx_d = sync_idx_q + 2'd1;
                    end
                end else begin
                    state_d      = StSkip;
                    sync_error_d = 1'b1;
                end
            end
            StActive: begin
                if (vs_fall) begin
                    line_done  = 1'b1;
                    frame_done = 1'b1;
                end else if (hs_fall) begin
                    line_done = 1'b1;
                    state_d   = StFrame;
                end else if (i_hs) begin
                    data_valid_d = 1'b1;
                    word_cnt_d   = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
                end
            end
            StSkip: begin
                if (vs_fall) begin
                    frame_done = 1'b1;
                end else if (hs_fall) begin
                    state_d = StFrame;
                end
            end
            default: state_d = StIdle;
        endcase

        if (line_done) begin
            pixel_count_d = word_cnt_q;
            line_count_d  = (line_count_q == 16'hFFFF) ? line_count_q : line_count_q + 16'd1;
        end
        if (frame_done) begin
            state_d       = StIdle;
            frame_end_d   = 1'b1;
            frame_count_d = frame_count_q + 32'd1;
        end
    end

    always_ff @(posedge i_cam_clk or posedge i_cam_rst) begin
        if (i_cam_rst) begin
            state_q       <= StIdle;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            sync_idx_q    <= '0;
            timeout_q     <= '0;
            word_cnt_q    <= '0;
            line_count_q  <= '0;
            pixel_count_q <= '0;
            frame_count_q <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_start_q  <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_q          <= i_vs;
            hs_q          <= i_hs;
            sync_idx_q    <= sync_idx_d;
            timeout_q     <= timeout_d;
            word_cnt_q    <= word_cnt_d;
            line_count_q  <= line_count_d;
            pixel_count_q <= pixel_count_d;
            frame_count_q <= frame_count_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_start_q  <= line_start_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign o_data        = data_q;
    assign o_data_valid  = data_valid_q;
    assign o_frame_start = frame_start_q;
    assign o_frame_end   = frame_end_q;
    assign o_line_start  = line_start_q;
    assign o_sync_error  = sync_error_q;
    assign o_line_count  = line_count_q;
    assign o_pixel_count = pixel_count_q;
    assign o_frame_count = frame_count_q;
    assign o_busy        = (state_q != StIdle);

endmodule
